// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
//   Transmit-side frame controller for the UART TX path. One CLK cycle is one
//   UART bit period. A byte is accepted from the parallel handshake while idle.
//   The block then sequences the start bit, DATA_WIDTH data bits taken from the
//   serializer, an optional parity bit and the stop bit onto TX_OUT.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | line high, waiting for DATA_VALID
//   START   | start bit (low); serializer shifts bit0 out for next cycle
//   DATA    | TX_OUT follows SER_DATA for DATA_WIDTH cycles
//   PARITY  | latched parity bit (only when par_en_q was set)
//   STOP    | stop bit (high), then back to IDLE
//
// Ports
//   CLK         in   TX bit clock, rising edge
//   RST         in   asynchronous reset, active low
//   P_DATA      in   parallel byte (also loaded by the serializer while !BUSY)
//   DATA_VALID  in   byte-available strobe, honoured only in IDLE
//   PAR_EN      in   1 = append parity bit (sampled at acceptance)
//   PAR_TYP     in   0 = even, 1 = odd (sampled at acceptance)
//   SER_DATA    in   registered data bit from the serializer, LSB first
//   SER_EN      out  serializer shift enable
//   BUSY        out  frame in progress; blocks serializer load
//   TX_OUT      out  UART line, idle high
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  SER_DATA,
  output logic                  SER_EN,
  output logic                  BUSY,
  output logic                  TX_OUT
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic             par_bit;
  logic             par_en_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      par_bit  <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (DATA_VALID) begin
            // Parity is computed from the byte at acceptance, so later changes
            // on P_DATA/PAR_TYP cannot disturb the frame in flight.
            par_en_q <= PAR_EN;
            par_bit  <= (^P_DATA) ^ PAR_TYP;
            state    <= ST_START;
          end
        end
        ST_START: begin
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          // Hold on the last bit instead of wrapping back to zero.
          if (bit_cnt == LAST_BIT) begin
            state <= par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        ST_PARITY: state <= ST_STOP;
        ST_STOP:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state (SER_DATA is registered in the
  // serializer), so TX_OUT carries no combinational path from the handshake.
  always_comb begin
    BUSY   = (state != ST_IDLE);
    // START plus the first DATA_WIDTH-1 data cycles: DATA_WIDTH shifts per frame.
    SER_EN = (state == ST_START) || ((state == ST_DATA) && (bit_cnt != LAST_BIT));
    case (state)
      ST_START:  TX_OUT = 1'b0;
      ST_DATA:   TX_OUT = SER_DATA;
      ST_PARITY: TX_OUT = par_bit;
      default:   TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Transmit-side frame controller for the UART TX path. It accepts a parallel byte handshake, sequences the start, data, optional parity and stop bits, and drives SER_EN to the serializer stage. It consumes the serializer's SER_DATA bit stream and muxes it with start, parity and stop levels onto the TX line. One CLK cycle equals one UART bit period; CLK is the TX bit clock.

Parameters:
DATA_WIDTH, 8, payload bits per frame; bit counter width is clog2(DATA_WIDTH).

Ports:
CLK  input  1  TX bit clock; all state updates on rising edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel byte; same bus the serializer loads
DATA_VALID  input  1  byte-available strobe; accepted only when BUSY=0
PAR_EN  input  1  1 = insert parity bit; sampled at acceptance
PAR_TYP  input  1  0 = even, 1 = odd; sampled at acceptance
SER_DATA  input  1  current data bit from serializer (registered, LSB first)
SER_EN  output  1  shift enable to serializer
BUSY  output  1  frame in progress; also gates serializer load
TX_OUT  output  1  UART line, idle high

Behaviour:
- Reset (async, RST=0): state=IDLE, bit_cnt=0, par_bit=0, par_en_q=0. Outputs: SER_EN=0, BUSY=0, TX_OUT=1. This holds even mid-frame; the line returns high immediately with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is free.
- IDLE:
  - TX_OUT=1, BUSY=0, SER_EN=0.
  - On DATA_VALID=1 at the edge: latch par_en_q=PAR_EN and par_bit = XOR-reduce(P_DATA) XOR PAR_TYP, then go to START.
  - The serializer loads P_DATA on the same edge because BUSY=0.
- START (1 cycle):
  - TX_OUT=0, BUSY=1, SER_EN=1. The serializer presents bit0 on SER_DATA from the next cycle.
  - bit_cnt←0. Go to DATA.
- DATA (DATA_WIDTH cycles):
  - TX_OUT=SER_DATA, BUSY=1.
  - SER_EN=1 while bit_cnt≠DATA_WIDTH-1, and 0 in the final data cycle. SER_EN is therefore high for exactly DATA_WIDTH cycles per frame, counting START.
  - bit_cnt increments each cycle.
  - When bit_cnt=DATA_WIDTH-1: go to PARITY if par_en_q=1, else STOP.
- PARITY (1 cycle): TX_OUT=par_bit, BUSY=1, SER_EN=0. Go to STOP.
- STOP (1 cycle): TX_OUT=1, BUSY=1, SER_EN=0. Go to IDLE unconditionally.
- DATA_VALID while BUSY=1 is ignored; there is no queuing. The upstream holds or re-presents the byte.
- Minimum gap between frames: 1 IDLE cycle. Frame length is 10 cycles without parity and 11 with parity.
- TX_OUT is a combinational mux of registered sources only (state, par_bit, SER_DATA); it is a function of state and never of inputs.
- PAR_EN and PAR_TYP changes mid-frame have no effect on the current frame.
- bit_cnt never wraps inside DATA; it is reset in START.
- Simultaneous RST assertion and DATA_VALID: reset wins.

Test Plan:
1. Reset, then idle 5 cycles -> TX_OUT=1, BUSY=0, SER_EN=0 throughout.
2. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, 1-cycle DATA_VALID (real serializer attached) -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, even parity 0, stop). BUSY high for 11 cycles. SER_EN high for exactly 8 cycles.
3. P_DATA=0x01, PAR_EN=1, PAR_TYP=1 -> parity bit=0. Repeat with PAR_TYP=0 -> parity bit=1.
4. P_DATA=0xFF, PAR_EN=0 -> 10-cycle frame 0,1,1,1,1,1,1,1,1,1. No parity slot.
5. DATA_VALID held high continuously with two different bytes -> second byte accepted only in the IDLE cycle after STOP. Pulses during BUSY are ignored and no frame is corrupted.
6. RST pulsed low during DATA bit 3 -> TX_OUT=1, BUSY=0, SER_EN=0 immediately (asynchronously). The next DATA_VALID starts a clean frame.
